// File: rtl/nab_seq_pkg.sv
// Shared constants and state encoding for the DAC sweep sequencer.
package nab_seq_pkg;

  localparam int DEF_DAC_XFER_CYCLES = 40;
  localparam int RES_W               = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_XFER   = 3'd3,
    ST_SETTLE = 3'd4,
    ST_SAMPLE = 3'd5,
    ST_RESULT = 3'd6
  } seq_state_e;

endpackage

// File: rtl/aux_averager.sv
// Selects one XADC aux channel and averages 2^LOG2_AVG captures spaced gap+1 cycles apart.
// done/avg_out are combinational in the final capture cycle so the caller can register them.
module aux_averager
  import nab_seq_pkg::*;
#(
  parameter int LOG2_AVG = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             start,
  input  logic [7:0]       gap,
  input  logic [1:0]       aux_sel,
  input  logic [RES_W-1:0] aux0,
  input  logic [RES_W-1:0] aux1,
  input  logic [RES_W-1:0] aux2,
  input  logic [RES_W-1:0] aux3,
  output logic             done,
  output logic [RES_W-1:0] avg_out
);

  localparam int ACC_W = RES_W + LOG2_AVG;
  localparam int CNT_W = LOG2_AVG + 1;
  localparam logic [CNT_W-1:0] AVG_LAST = CNT_W'((1 << LOG2_AVG) - 1);

  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] cap_cnt_r;
  logic [7:0]       gap_cnt_r;
  logic             active_r;

  logic [RES_W-1:0] sel_s;
  logic             capture_s;
  logic [CNT_W-1:0] cur_cnt_s;
  logic [ACC_W-1:0] base_s;
  logic [ACC_W-1:0] sum_s;

  // Channel mux
  always_comb begin
    case (aux_sel)
      2'd0:    sel_s = aux0;
      2'd1:    sel_s = aux1;
      2'd2:    sel_s = aux2;
      2'd3:    sel_s = aux3;
      default: sel_s = aux0;
    endcase
  end

  // Capture decision; the start cycle restarts the sum from zero
  always_comb begin
    capture_s = start | (active_r & (gap_cnt_r == 8'd0));
    if (start) begin
      cur_cnt_s = '0;
      base_s    = '0;
    end else begin
      cur_cnt_s = cap_cnt_r;
      base_s    = acc_r;
    end
    sum_s   = base_s + ACC_W'(sel_s);
    done    = capture_s & (cur_cnt_s == AVG_LAST);
    avg_out = RES_W'(sum_s >> LOG2_AVG);
  end

  // Accumulator and capture/gap counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r     <= '0;
      cap_cnt_r <= '0;
      gap_cnt_r <= 8'd0;
      active_r  <= 1'b0;
    end else if (clear) begin
      acc_r     <= '0;
      cap_cnt_r <= '0;
      gap_cnt_r <= 8'd0;
      active_r  <= 1'b0;
    end else if (capture_s) begin
      acc_r     <= sum_s;
      cap_cnt_r <= cur_cnt_s + CNT_W'(1);
      gap_cnt_r <= gap;
      active_r  <= ~done;
    end else if (active_r) begin
      gap_cnt_r <= gap_cnt_r - 8'd1;
    end
  end

endmodule

// File: rtl/dac_sweep_sequencer.sv
// Steps the PMOD DAC through a code sweep and streams one averaged XADC reading per step.
module dac_sweep_sequencer
  import nab_seq_pkg::*;
#(
  parameter int DAC_XFER_CYCLES = DEF_DAC_XFER_CYCLES,
  parameter int LOG2_AVG        = 2,
  parameter int SETTLE_W        = 32
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESETN,
  input  logic                cfg_start,
  input  logic                cfg_abort,
  input  logic [15:0]         cfg_start_code,
  input  logic [15:0]         cfg_step,
  input  logic [15:0]         cfg_num_steps,
  input  logic [SETTLE_W-1:0] cfg_settle_cycles,
  input  logic [7:0]          cfg_sample_gap,
  input  logic [1:0]          cfg_aux_sel,
  input  logic [RES_W-1:0]    measured_aux0,
  input  logic [RES_W-1:0]    measured_aux1,
  input  logic [RES_W-1:0]    measured_aux2,
  input  logic [RES_W-1:0]    measured_aux3,
  output logic [15:0]         dac_din,
  output logic                dac_load_din,
  output logic                dac_start,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [15:0]         res_code,
  output logic [RES_W-1:0]    res_sample,
  output logic [15:0]         res_index,
  output logic                res_clipped,
  output logic                busy,
  output logic                done,
  output logic                aborted
);

  localparam logic [SETTLE_W-1:0] XFER_LAST = SETTLE_W'(DAC_XFER_CYCLES - 1);

  seq_state_e          state_r;
  logic [15:0]         code_r;
  logic [15:0]         step_r;
  logic [15:0]         num_steps_r;
  logic [15:0]         index_r;
  logic [SETTLE_W-1:0] settle_r;
  logic [SETTLE_W-1:0] wait_r;
  logic [7:0]          gap_r;
  logic [1:0]          aux_sel_r;
  logic                clipped_r;
  logic                avg_start_r;

  logic [16:0]         sum17_s;
  logic [15:0]         next_code_s;
  logic                next_clip_s;
  logic                last_step_s;
  logic                abort_s;
  logic                avg_done_s;
  logic [RES_W-1:0]    avg_out_s;

  // Saturating code step and end-of-sweep detection
  always_comb begin
    sum17_s = {1'b0, code_r} + {1'b0, step_r};
    if (sum17_s[16]) begin
      next_code_s = 16'hFFFF;
    end else begin
      next_code_s = sum17_s[15:0];
    end
    next_clip_s = clipped_r | sum17_s[16];
    last_step_s = ((index_r + 16'd1) == num_steps_r);
    abort_s     = cfg_abort & (state_r != ST_IDLE);
  end

  aux_averager #(
    .LOG2_AVG (LOG2_AVG)
  ) u_avg (
    .clk     (S_AXI_ACLK),
    .rst_n   (S_AXI_ARESETN),
    .clear   (abort_s),
    .start   (avg_start_r),
    .gap     (gap_r),
    .aux_sel (aux_sel_r),
    .aux0    (measured_aux0),
    .aux1    (measured_aux1),
    .aux2    (measured_aux2),
    .aux3    (measured_aux3),
    .done    (avg_done_s),
    .avg_out (avg_out_s)
  );

  // Sequencer FSM with registered strobes and result payload
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_r      <= ST_IDLE;
      code_r       <= 16'd0;
      step_r       <= 16'd0;
      num_steps_r  <= 16'd0;
      index_r      <= 16'd0;
      settle_r     <= '0;
      wait_r       <= '0;
      gap_r        <= 8'd0;
      aux_sel_r    <= 2'd0;
      clipped_r    <= 1'b0;
      avg_start_r  <= 1'b0;
      dac_din      <= 16'd0;
      dac_load_din <= 1'b0;
      dac_start    <= 1'b0;
      res_valid    <= 1'b0;
      res_code     <= 16'd0;
      res_sample   <= '0;
      res_index    <= 16'd0;
      res_clipped  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      dac_load_din <= 1'b0;
      dac_start    <= 1'b0;
      done         <= 1'b0;
      avg_start_r  <= 1'b0;
      if (abort_s) begin
        state_r   <= ST_IDLE;
        res_valid <= 1'b0;
        busy      <= 1'b0;
        aborted   <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (cfg_start) begin
              if (cfg_abort) begin
                aborted <= 1'b1;
              end else if (cfg_num_steps == 16'd0) begin
                done <= 1'b1;
              end else begin
                code_r       <= cfg_start_code;
                step_r       <= cfg_step;
                num_steps_r  <= cfg_num_steps;
                settle_r     <= cfg_settle_cycles;
                gap_r        <= cfg_sample_gap;
                aux_sel_r    <= cfg_aux_sel;
                index_r      <= 16'd0;
                clipped_r    <= 1'b0;
                aborted      <= 1'b0;
                busy         <= 1'b1;
                dac_din      <= cfg_start_code;
                dac_load_din <= 1'b1;
                state_r      <= ST_LOAD;
              end
            end
          end
          ST_LOAD: begin
            dac_start <= 1'b1;
            state_r   <= ST_START;
          end
          ST_START: begin
            wait_r  <= XFER_LAST;
            state_r <= ST_XFER;
          end
          ST_XFER: begin
            if (wait_r != '0) begin
              wait_r <= wait_r - SETTLE_W'(1);
            end else if (settle_r == '0) begin
              avg_start_r <= 1'b1;
              state_r     <= ST_SAMPLE;
            end else begin
              wait_r  <= settle_r - SETTLE_W'(1);
              state_r <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (wait_r != '0) begin
              wait_r <= wait_r - SETTLE_W'(1);
            end else begin
              avg_start_r <= 1'b1;
              state_r     <= ST_SAMPLE;
            end
          end
          ST_SAMPLE: begin
            if (avg_done_s) begin
              res_valid   <= 1'b1;
              res_sample  <= avg_out_s;
              res_code    <= code_r;
              res_index   <= index_r;
              res_clipped <= clipped_r;
              state_r     <= ST_RESULT;
            end
          end
          ST_RESULT: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              if (last_step_s) begin
                busy    <= 1'b0;
                done    <= 1'b1;
                state_r <= ST_IDLE;
              end else begin
                index_r      <= index_r + 16'd1;
                code_r       <= next_code_s;
                clipped_r    <= next_clip_s;
                dac_din      <= next_code_s;
                dac_load_din <= 1'b1;
                state_r      <= ST_LOAD;
              end
            end
          end
          default: begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dac_sweep_sequencer.sv
// Directed vector bench for dac_sweep_sequencer (DAC_XFER_CYCLES=4, LOG2_AVG=2).
module tb_dac_sweep_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start, cfg_abort;
  logic [15:0] cfg_start_code, cfg_step, cfg_num_steps;
  logic [31:0] cfg_settle_cycles;
  logic [7:0]  cfg_sample_gap;
  logic [1:0]  cfg_aux_sel;
  logic [11:0] aux0, aux1, aux2, aux3;
  logic [15:0] dac_din;
  logic        dac_load_din, dac_start, res_valid, res_ready;
  logic [15:0] res_code, res_index;
  logic [11:0] res_sample;
  logic        res_clipped, busy, done, aborted;

  always #5 clk = ~clk;

  dac_sweep_sequencer #(.DAC_XFER_CYCLES(4), .LOG2_AVG(2), .SETTLE_W(32)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_start_code(cfg_start_code), .cfg_step(cfg_step), .cfg_num_steps(cfg_num_steps),
    .cfg_settle_cycles(cfg_settle_cycles), .cfg_sample_gap(cfg_sample_gap), .cfg_aux_sel(cfg_aux_sel),
    .measured_aux0(aux0), .measured_aux1(aux1), .measured_aux2(aux2), .measured_aux3(aux3),
    .dac_din(dac_din), .dac_load_din(dac_load_din), .dac_start(dac_start),
    .res_valid(res_valid), .res_ready(res_ready), .res_code(res_code), .res_sample(res_sample),
    .res_index(res_index), .res_clipped(res_clipped), .busy(busy), .done(done), .aborted(aborted)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // DAC strobe monitor, sampled on the falling edge
  int          load_cnt = 0;
  int          start_cnt = 0;
  logic [15:0] load_codes [$];
  always @(negedge clk) begin
    if (dac_load_din) begin
      load_cnt++;
      load_codes.push_back(dac_din);
    end
    if (dac_start) start_cnt++;
  end

  typedef struct {
    logic [15:0]       start_code;
    logic [15:0]       step;
    logic [15:0]       num_steps;
    logic [31:0]       settle;
    logic [7:0]        gap;
    logic [1:0]        sel;
    int                lat;
    logic [11:0]       sample;
    logic [2:0][15:0]  codes;
    logic [2:0]        clip;
  } vec_t;

  vec_t vecs [4];

  logic [15:0] r_code [$];
  logic [11:0] r_sample [$];
  logic [15:0] r_index [$];
  logic        r_clip [$];
  int first_lat, done_at, ndone, busy_at_done, busy_before_done, unstable;
  int load0, start0, loads_in_hold;
  logic busy_seen, aborted_c0, finished, prev_busy;

  task automatic run_sweep(input logic [15:0] sc, input logic [15:0] st, input logic [15:0] ns,
                           input logic [31:0] se, input logic [7:0] gp, input logic [1:0] sel,
                           input int abort_at, input int restart_at, input int hold,
                           input int aux_s, input int max_cyc);
    logic [44:0] snap;
    logic        holding;
    int          k;
    cfg_start_code = sc; cfg_step = st; cfg_num_steps = ns; cfg_settle_cycles = se;
    cfg_sample_gap = gp; cfg_aux_sel = sel; res_ready = 1'b1; cfg_abort = 1'b0;
    r_code.delete(); r_sample.delete(); r_index.delete(); r_clip.delete();
    first_lat = -1; done_at = -1; ndone = 0; busy_at_done = 0; busy_before_done = 0;
    unstable = 0; loads_in_hold = -1; busy_seen = 1'b0; finished = 1'b0; prev_busy = 1'b0;
    snap = '0;
    load0 = load_cnt; start0 = start_cnt;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      if (aux_s >= 0) begin
        k = c - (6 + aux_s);
        if (k >= 0 && k <= 6 && (k % 2) == 0) aux2 = 12'(4 * (k / 2));
        else aux2 = 12'hFFF;
      end
      cfg_abort = (c == abort_at);
      if (c == restart_at) begin
        cfg_start = 1'b1; cfg_start_code = 16'h9999; cfg_num_steps = 16'd5; cfg_step = 16'h0001;
      end else begin
        cfg_start = 1'b0;
      end
      if (c == 0) aborted_c0 = aborted;
      if (abort_at >= 0 && c == abort_at + 1) begin
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_flag", {63'd0, aborted}, 64'd1);
        chk("abort_valid", {63'd0, res_valid}, 64'd0);
      end
      if (res_valid && first_lat < 0) begin
        first_lat = c;
        snap = {res_code, res_sample, res_index, res_clipped};
      end
      holding = (hold > 0 && first_lat >= 0 && c < first_lat + hold);
      res_ready = !holding;
      if (hold > 0 && first_lat >= 0 && c == first_lat + hold) loads_in_hold = load_cnt - load0;
      if (holding && (!res_valid || {res_code, res_sample, res_index, res_clipped} != snap)) unstable++;
      if (res_valid && res_ready) begin
        r_code.push_back(res_code); r_sample.push_back(res_sample);
        r_index.push_back(res_index); r_clip.push_back(res_clipped);
      end
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = c;
        if (busy) busy_at_done++;
        if (prev_busy) busy_before_done++;
      end
      if (busy) busy_seen = 1'b1;
      prev_busy = busy;
      if (done && abort_at < 0) begin finished = 1'b1; break; end
      if (abort_at >= 0 && c == abort_at + 30) begin finished = 1'b1; break; end
      @(posedge clk); #1;
    end
    cfg_abort = 1'b0; cfg_start = 1'b0; res_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("finished", {63'd0, finished}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0; res_ready = 1'b1;
    cfg_start_code = 16'd0; cfg_step = 16'd0; cfg_num_steps = 16'd0;
    cfg_settle_cycles = 32'd0; cfg_sample_gap = 8'd0; cfg_aux_sel = 2'd0;
    aux0 = 12'h111; aux1 = 12'h5A3; aux2 = 12'h222; aux3 = 12'h333;

    vecs[0] = '{16'h0100, 16'h0010, 16'd3, 32'd10, 8'd0, 2'd1, 20, 12'h5A3,
                {16'h0120, 16'h0110, 16'h0100}, 3'b000};
    vecs[1] = '{16'hFFF0, 16'h0020, 16'd2, 32'd0,  8'd2, 2'd3, 16, 12'h333,
                {16'h0000, 16'hFFFF, 16'hFFF0}, 3'b010};
    vecs[2] = '{16'h8000, 16'h4000, 16'd3, 32'd3,  8'd0, 2'd0, 13, 12'h111,
                {16'hFFFF, 16'hC000, 16'h8000}, 3'b100};
    vecs[3] = '{16'h0000, 16'hFFFF, 16'd3, 32'd1,  8'd1, 2'd2, 14, 12'h222,
                {16'hFFFF, 16'hFFFF, 16'h0000}, 3'b100};

    #22;
    chk("rst_dac", {46'd0, dac_din, dac_load_din, dac_start}, 64'd0);
    chk("rst_res", {18'd0, res_valid, res_code, res_sample, res_index, res_clipped}, 64'd0);
    chk("rst_status", {61'd0, busy, done, aborted}, 64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven full sweeps with res_ready held high
    for (int v = 0; v < 4; v++) begin
      run_sweep(vecs[v].start_code, vecs[v].step, vecs[v].num_steps, vecs[v].settle,
                vecs[v].gap, vecs[v].sel, -1, -1, 0, -1, 400);
      chk($sformatf("v%0d_latency", v), 64'(first_lat), 64'(vecs[v].lat));
      chk($sformatf("v%0d_nres", v), 64'(r_code.size()), 64'(vecs[v].num_steps));
      chk($sformatf("v%0d_ndone", v), 64'(ndone), 64'd1);
      chk($sformatf("v%0d_busy_at_done", v), 64'(busy_at_done), 64'd0);
      chk($sformatf("v%0d_busy_before_done", v), 64'(busy_before_done), 64'd1);
      chk($sformatf("v%0d_loads", v), 64'(load_cnt - load0), 64'(vecs[v].num_steps));
      chk($sformatf("v%0d_starts", v), 64'(start_cnt - start0), 64'(vecs[v].num_steps));
      for (int i = 0; i < int'(vecs[v].num_steps); i++) begin
        if (i < r_code.size()) begin
          chk($sformatf("v%0d_code%0d", v, i), 64'(r_code[i]), 64'(vecs[v].codes[i]));
          chk($sformatf("v%0d_sample%0d", v, i), 64'(r_sample[i]), 64'(vecs[v].sample));
          chk($sformatf("v%0d_index%0d", v, i), 64'(r_index[i]), 64'(i));
          chk($sformatf("v%0d_clip%0d", v, i), 64'(r_clip[i]), 64'(vecs[v].clip[i]));
        end
        if (load0 + i < load_codes.size())
          chk($sformatf("v%0d_dac_din%0d", v, i), 64'(load_codes[load0 + i]), 64'(vecs[v].codes[i]));
      end
    end

    // Stepping aux2 with gap=1: captures 0,4,8,C two cycles apart, junk in between
    run_sweep(16'h0040, 16'h0001, 16'd1, 32'd2, 8'd1, 2'd2, -1, -1, 0, 2, 400);
    aux2 = 12'h222;
    chk("step_latency", 64'(first_lat), 64'd15);
    chk("step_sample", (r_sample.size() > 0) ? 64'(r_sample[0]) : 64'hDEAD, 64'h006);

    // Back-pressure: ready low for 50 cycles on the first result
    run_sweep(16'h0300, 16'h0005, 16'd2, 32'd0, 8'd0, 2'd1, -1, -1, 50, -1, 600);
    chk("bp_unstable", 64'(unstable), 64'd0);
    chk("bp_loads_in_hold", 64'(loads_in_hold), 64'd1);
    chk("bp_nres", 64'(r_code.size()), 64'd2);
    chk("bp_code1", (r_code.size() > 1) ? 64'(r_code[1]) : 64'hDEAD, 64'h0305);
    chk("bp_ndone", 64'(ndone), 64'd1);

    // Start together with abort in IDLE: abort wins
    cfg_num_steps = 16'd2; cfg_start = 1'b1; cfg_abort = 1'b1; load0 = load_cnt;
    @(posedge clk); #1;
    cfg_start = 1'b0; cfg_abort = 1'b0;
    chk("idle_abort_flag", {63'd0, aborted}, 64'd1);
    chk("idle_abort_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    chk("idle_abort_loads", 64'(load_cnt - load0), 64'd0);

    // Abort during SETTLE of the first step
    run_sweep(16'h0200, 16'h0100, 16'd3, 32'd20, 8'd0, 2'd1, 10, -1, 0, -1, 100);
    chk("abort_start_clears", {63'd0, aborted_c0}, 64'd0);
    chk("abort_ndone", 64'(ndone), 64'd0);
    chk("abort_nres", 64'(r_code.size()), 64'd0);
    chk("abort_starts", 64'(start_cnt - start0), 64'd1);
    chk("abort_sticky", {63'd0, aborted}, 64'd1);

    // New start clears aborted; a start pulse while busy is ignored
    run_sweep(16'h1234, 16'h0001, 16'd1, 32'd0, 8'd0, 2'd0, -1, 5, 0, -1, 400);
    chk("restart_aborted_c0", {63'd0, aborted_c0}, 64'd0);
    chk("restart_nres", 64'(r_code.size()), 64'd1);
    chk("restart_code", (r_code.size() > 0) ? 64'(r_code[0]) : 64'hDEAD, 64'h1234);
    chk("restart_loads", 64'(load_cnt - load0), 64'd1);
    chk("restart_ndone", 64'(ndone), 64'd1);

    // num_steps = 0: done the next cycle, never busy, no strobes
    run_sweep(16'h0500, 16'h0001, 16'd0, 32'd0, 8'd0, 2'd0, -1, -1, 0, -1, 20);
    chk("zero_done_at", 64'(done_at), 64'd0);
    chk("zero_ndone", 64'(ndone), 64'd1);
    chk("zero_busy_seen", {63'd0, busy_seen}, 64'd0);
    chk("zero_loads", 64'(load_cnt - load0), 64'd0);
    chk("zero_starts", 64'(start_cnt - start0), 64'd0);

    // Reset in the middle of a sweep clears every output at once
    cfg_num_steps = 16'd3; cfg_start_code = 16'h0777; cfg_settle_cycles = 32'd5;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("midrst_busy_before", {63'd0, busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_dac", {46'd0, dac_din, dac_load_din, dac_start}, 64'd0);
    chk("midrst_res", {18'd0, res_valid, res_code, res_sample, res_index, res_clipped}, 64'd0);
    chk("midrst_status", {61'd0, busy, done, aborted}, 64'd0);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("postrst_idle", {61'd0, busy, dac_load_din, dac_start}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
